dfir_cfg_arb: RTL

DFIR_CFG_ARB -- requirements
Module: dfir_cfg_arb

---
 rtl/dfir_cfg_arb.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dfir_cfg_arb.sv
// dfir_cfg_arb: round-robin arbiter that lets NUM_REQ requesters share one
// DFIR configuration port. A granted requester keeps the grant until the
// controller reports completion (or the optional watchdog expires).
// Optional feature: define DFIR_CFG_ARB_TIMEOUT_EN to enable the watchdog
// that aborts stalled transactions with an error pulse.
module dfir_cfg_arb #(
    parameter int NUM_REQ        = 4,
    parameter int CONFIG_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_REQ-1:0]              isConfigReq,
    input  logic [NUM_REQ*CONFIG_WIDTH-1:0] Data_Config_In,
    output logic [NUM_REQ-1:0]              isConfigGnt,
    output logic [NUM_REQ-1:0]              isConfigDone_Req,
    output logic [NUM_REQ-1:0]              isConfigErr_Req,
    output logic                            isConfig_Out,
    output logic [CONFIG_WIDTH-1:0]         Data_Config_Out,
    input  logic                            isConfigACK_In,
    input  logic                            isConfigDone_In,
    output logic                            Busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        STREAM,
        RELEASE
    } state_t;

    state_t                  state;
    state_t                  nextState;
    logic [IDX_W-1:0]        grantIdx;
    logic [IDX_W-1:0]        nextGrantIdx;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        winIdx;
    logic                    winFound;
    logic                    relDone;
    logic                    nextRelDone;
    logic                    wdExpire;
    logic [CONFIG_WIDTH-1:0] dataReg;
    logic [NUM_REQ-1:0]      grantOneHot;

    // Round-robin scan starting at ptr, wrapping past the last requester
    always_comb begin
        int unsigned cand;
        winFound = 1'b0;
        winIdx   = '0;
        cand     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!winFound && isConfigReq[IDX_W'(cand)]) begin
                winFound = 1'b1;
                winIdx   = IDX_W'(cand);
            end
        end
    end

`ifdef DFIR_CFG_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wdCount;

    // Watchdog: zeroed in ISSUE so it starts at 0 on entering WAIT_ACK
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wdCount <= '0;
        end else if (state == WAIT_ACK || state == STREAM) begin
            wdCount <= wdCount + 1'b1;
        end else begin
            wdCount <= '0;
        end
    end

    assign wdExpire = (state == WAIT_ACK || state == STREAM) &&
                      (wdCount == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign wdExpire = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; a completion seen together with expiry counts as done
    always_comb begin
        nextState    = state;
        nextRelDone  = relDone;
        nextGrantIdx = grantIdx;
        case (state)
            IDLE: begin
                if (winFound) begin
                    nextState    = ISSUE;
                    nextGrantIdx = winIdx;
                end
            end
            ISSUE: begin
                nextState = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (isConfigDone_In) begin
                    nextState   = RELEASE;
                    nextRelDone = 1'b1;
                end else if (isConfigACK_In) begin
                    nextState = STREAM;
                end else if (wdExpire) begin
                    nextState   = RELEASE;
                    nextRelDone = 1'b0;
                end
            end
            STREAM: begin
                if (isConfigDone_In) begin
                    nextState   = RELEASE;
                    nextRelDone = 1'b1;
                end else if (wdExpire) begin
                    nextState   = RELEASE;
                    nextRelDone = 1'b0;
                end
            end
            RELEASE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Grant index, exit reason, rotating pointer and registered data word
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grantIdx <= '0;
            relDone  <= 1'b0;
            ptr      <= '0;
            dataReg  <= '0;
        end else begin
            grantIdx <= nextGrantIdx;
            relDone  <= nextRelDone;
            if (state == RELEASE) begin
                if (grantIdx == IDX_W'(NUM_REQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= grantIdx + 1'b1;
                end
            end
            if (nextState == ISSUE || nextState == WAIT_ACK || nextState == STREAM) begin
                dataReg <= Data_Config_In[nextGrantIdx*CONFIG_WIDTH +: CONFIG_WIDTH];
            end else begin
                dataReg <= '0;
            end
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        grantOneHot           = '0;
        grantOneHot[grantIdx] = 1'b1;
        Busy                  = (state != IDLE);
        isConfig_Out          = (state == ISSUE);
        isConfigGnt           = (state != IDLE) ? grantOneHot : '0;
        isConfigDone_Req      = (state == RELEASE && relDone) ? grantOneHot : '0;
`ifdef DFIR_CFG_ARB_TIMEOUT_EN
        isConfigErr_Req       = (state == RELEASE && !relDone) ? grantOneHot : '0;
`else
        isConfigErr_Req       = '0;
`endif
        Data_Config_Out       = dataReg;
    end

endmodule
